sifive_scope_amba_prot_tracker: RTL
===================================

Name: sifive_scope_amba_prot_tracker

Overview:
- Passive read-channel monitor that produces the decoded AMBA protection/cache attribute bundle (fetch, secure, privileged, writealloc, readalloc, modifiable, bufferable) consumed by the scope's amba_prot sink.
- On each AXI4 AR handshake it decodes ARPROT/ARCACHE into the seven attributes and pushes them into an in-order outstanding-transaction FIFO.
- It pops the FIFO on each final R beat, so the head entry always carries the attributes of the read currently returning data.
- It also keeps sticky error flags and a saturating count of reserved ARCACHE encodings.

Parameters:
- DEPTH, 8, outstanding-read FIFO entries; power of two, 2..32.
- CNT_W, 16, width of the reserved-encoding counter.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ar_valid  in  1  observed AR valid.
- ar_ready  in  1  observed AR ready.
- ar_prot  in  3  observed ARPROT.
- ar_cache  in  4  observed ARCACHE.
- r_valid  in  1  observed R valid.
- r_ready  in  1  observed R ready.
- r_last  in  1  observed RLAST.
- head_valid  out  1  FIFO non-empty; head attributes are meaningful.
- head_fetch  out  1  ARPROT[2] of the head entry.
- head_secure  out  1  ~ARPROT[1] of the head entry.
- head_privileged  out  1  ARPROT[0] of the head entry.
- head_writealloc  out  1  ARCACHE[3] of the head entry.
- head_readalloc  out  1  ARCACHE[2] of the head entry.
- head_modifiable  out  1  ARCACHE[1] of the head entry.
- head_bufferable  out  1  ARCACHE[0] of the head entry.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky; an AR handshake arrived while full.
- underflow  out  1  sticky; a last R beat arrived while empty.
- reserved_cnt  out  CNT_W  saturating count of reserved ARCACHE encodings.
- clear  in  1  synchronous clear of overflow, underflow and reserved_cnt only.

Behaviour:
- Events:
  - push = ar_valid & ar_ready.
  - pop = r_valid & r_ready & r_last.
  - Non-last R beats are ignored.
- Decode is combinational on ar_*. The stored entry is 7 bits, in the port-list order above.
- Reset: FIFO empty, occupancy=0, head_valid=0, all head_* = 0, overflow=0, underflow=0, reserved_cnt=0.
- Head outputs are forced to 0 whenever head_valid=0.
- FIFO:
  - Registered storage; read and write pointers wrap modulo DEPTH.
  - occupancy updates one cycle after the handshake.
  - A pushed entry becomes visible at the head in the cycle after the push when the FIFO was empty. There is no same-cycle bypass.
- Push and pop in the same cycle:
  - Non-empty: both take effect and occupancy is unchanged.
  - Empty: the pop is an underflow (underflow<=1, pop ignored); the push is stored, so occupancy ends at 1.
  - Full: the pop frees an entry and the push is accepted. No overflow; occupancy stays DEPTH.
- Full without a pop: the push is dropped, overflow<=1, FIFO contents unchanged.
- Empty with a pop and no push: underflow<=1; pointers unchanged.
- Reserved encoding: ar_cache[1]==0 and ar_cache[3:2]!=0, sampled on push.
  - reserved_cnt increments by 1 and saturates at all-ones.
  - It is counted even when the push is dropped for overflow.
  - The entry is still stored with its raw decoded bits.
- clear:
  - Clears overflow, underflow and reserved_cnt in the next cycle and does not affect the FIFO.
  - If an error event coincides with clear, the event wins: the flag sets, or the count goes to 1.
- reset asserted mid-operation discards all entries in one cycle. The ar/r inputs are ignored during reset.
- The block never drives the AXI bus; it is purely observational.

Test Plan:
- Single read: AR push with prot=3'b101, cache=4'b0011 -> next cycle head_valid=1, fetch=1, secure=1, privileged=1, writealloc=0, readalloc=0, modifiable=1, bufferable=1, occupancy=1. Then R beats with last=0,0,1 -> pop only on the third beat; head_valid=0 and all head_*=0 the following cycle.
- Ordering: push 3 ARs with prot=0,1,2 (cache=0) -> on successive pops head_privileged=0,1,0 and head_secure=1,1,0.
- Full (DEPTH=8): 9 pushes without pops -> occupancy=8, overflow=1 after the 9th, and the head still holds the first entry. Then simultaneous push+pop while full -> no new overflow, occupancy stays 8.
- Empty: a last R beat with no push -> underflow=1, occupancy=0. Simultaneous push+pop on empty -> underflow=1, occupancy=1.
- Reserved encoding: cache=4'b1100 pushed 3 times -> reserved_cnt=3. With CNT_W=2, five such pushes -> reserved_cnt=3 (saturated). clear coincident with a reserved push -> reserved_cnt=1.
- Reset mid-stream: 5 outstanding entries, assert reset for 1 cycle -> occupancy=0, head_valid=0, flags=0. The next push is the new head.

Source files
------------

// File: rtl/sifive_scope_amba_prot_tracker.sv
// Passive AXI4 read-channel monitor: decodes ARPROT/ARCACHE on each AR handshake and tracks the
// attributes of outstanding reads in order, exposing the entry whose data is currently returning.
module sifive_scope_amba_prot_tracker #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ar_valid,
    input  logic                     ar_ready,
    input  logic [2:0]               ar_prot,
    input  logic [3:0]               ar_cache,
    input  logic                     r_valid,
    input  logic                     r_ready,
    input  logic                     r_last,
    output logic                     head_valid,
    output logic                     head_fetch,
    output logic                     head_secure,
    output logic                     head_privileged,
    output logic                     head_writealloc,
    output logic                     head_readalloc,
    output logic                     head_modifiable,
    output logic                     head_bufferable,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic                     underflow,
    output logic [CNT_W-1:0]         reserved_cnt,
    input  logic                     clear
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 7;

    logic                push;
    logic                pop;
    logic                empty;
    logic                full;
    logic                pop_ok;
    logic                push_ok;
    logic                ovf_evt;
    logic                udf_evt;
    logic                res_evt;
    logic [EntW-1:0]     ar_entry;
    logic [EntW-1:0]     head_entry;

    logic [EntW-1:0]     mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [PtrW-1:0]     rd_ptr_d;
    logic [CntW-1:0]     count_q;
    logic [CntW-1:0]     count_d;
    logic                overflow_q;
    logic                overflow_d;
    logic                underflow_q;
    logic                underflow_d;
    logic [CNT_W-1:0]    res_cnt_q;
    logic [CNT_W-1:0]    res_cnt_d;

    // Entry layout, MSB first: fetch, secure, privileged, writealloc, readalloc, modifiable,
    // bufferable.
    always_comb begin
        ar_entry = {ar_prot[2], ~ar_prot[1], ar_prot[0],
                    ar_cache[3], ar_cache[2], ar_cache[1], ar_cache[0]};
    end

    always_comb begin
        push    = ar_valid & ar_ready;
        pop     = r_valid & r_ready & r_last;
        empty   = (count_q == '0);
        full    = (count_q == CntW'(DEPTH));
        pop_ok  = pop & ~empty;
        // A pop while full frees a slot for a coincident push.
        push_ok = push & (~full | pop_ok);
        ovf_evt = push & full & ~pop_ok;
        udf_evt = pop & empty;
        res_evt = push & ~ar_cache[1] & (ar_cache[3:2] != 2'b00);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    // Error events coincident with clear win over the clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        res_cnt_d   = res_cnt_q;
        if (clear) begin
            overflow_d  = ovf_evt;
            underflow_d = udf_evt;
            res_cnt_d   = CNT_W'(res_evt);
        end else begin
            overflow_d  = overflow_q | ovf_evt;
            underflow_d = underflow_q | udf_evt;
            if (res_evt && !(&res_cnt_q)) begin
                res_cnt_d = res_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= ar_entry;
        end
    end

    always_comb begin
        head_entry = empty ? '0 : mem_q[rd_ptr_q];
    end

    assign head_valid      = ~empty;
    assign head_fetch      = head_entry[6];
    assign head_secure     = head_entry[5];
    assign head_privileged = head_entry[4];
    assign head_writealloc = head_entry[3];
    assign head_readalloc  = head_entry[2];
    assign head_modifiable = head_entry[1];
    assign head_bufferable = head_entry[0];
    assign occupancy       = count_q;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;
    assign reserved_cnt    = res_cnt_q;

endmodule
